// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin (mod 2^WIDTH) plus borrow-out,
// one bit per clock LSB first, with a start/busy/done handshake.
module serial_subtractor #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             b_out
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             bor_q, bor_d;
  logic             b_out_q, b_out_d;

  logic             a_i, b_i, d_i, bor_nx;
  logic [WIDTH:0]   res_shift;

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    res_d   = res_q;
    diff_d  = diff_q;
    cnt_d   = cnt_q;
    bor_d   = bor_q;
    b_out_d = b_out_q;

    a_i    = a_sh_q[0];
    b_i    = b_sh_q[0];
    d_i    = a_i ^ b_i ^ bor_q;
    bor_nx = (~a_i & b_i) | (~(a_i ^ b_i) & bor_q);
    // Shifting through a WIDTH+1 vector keeps the MSB insert legal for WIDTH=1
    res_shift = {d_i, res_q} >> 1;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          bor_d   = bin;
          cnt_d   = '0;
          res_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        bor_d  = bor_nx;
        res_d  = res_shift[WIDTH-1:0];
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          diff_d  = res_shift[WIDTH-1:0];
          b_out_d = bor_nx;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      diff_q  <= '0;
      cnt_q   <= '0;
      bor_q   <= 1'b0;
      b_out_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      res_q   <= res_d;
      diff_q  <= diff_d;
      cnt_q   <= cnt_d;
      bor_q   <= bor_d;
      b_out_q <= b_out_d;
    end
  end

  assign busy  = (state_q != IDLE);
  assign done  = (state_q == DONE);
  assign diff  = diff_q;
  assign b_out = b_out_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and exhaustive checks of serial_subtractor at WIDTH 4, 1 and 8.
module tb_serial_subtractor;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       start4 = 1'b0, bin4 = 1'b0, busy4, done4, bout4;
  logic [3:0] a4 = '0, b4 = '0, diff4;
  logic       start1 = 1'b0, bin1 = 1'b0, busy1, done1, bout1;
  logic [0:0] a1 = '0, b1 = '0, diff1;
  logic       start8 = 1'b0, bin8 = 1'b0, busy8, done8, bout8;
  logic [7:0] a8 = '0, b8 = '0, diff8;

  serial_subtractor #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .bin(bin4),
    .busy(busy4), .done(done4), .diff(diff4), .b_out(bout4)
  );
  serial_subtractor #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .bin(bin1),
    .busy(busy1), .done(done1), .diff(diff1), .b_out(bout1)
  );
  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .bin(bin8),
    .busy(busy8), .done(done8), .diff(diff8), .b_out(bout8)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input int w, input logic s, input logic [7:0] a, input logic [7:0] b,
                       input logic bi);
    case (w)
      1: begin start1 = s; a1 = a[0]; b1 = b[0]; bin1 = bi; end
      4: begin start4 = s; a4 = a[3:0]; b4 = b[3:0]; bin4 = bi; end
      default: begin start8 = s; a8 = a; b8 = b; bin8 = bi; end
    endcase
  endtask

  function automatic logic get_done(input int w);
    return (w == 1) ? done1 : (w == 4) ? done4 : done8;
  endfunction
  function automatic logic get_busy(input int w);
    return (w == 1) ? busy1 : (w == 4) ? busy4 : busy8;
  endfunction
  function automatic logic get_bout(input int w);
    return (w == 1) ? bout1 : (w == 4) ? bout4 : bout8;
  endfunction
  function automatic logic [7:0] get_diff(input int w);
    return (w == 1) ? {7'b0, diff1} : (w == 4) ? {4'b0, diff4} : diff8;
  endfunction

  // One full operation from IDLE; checks latency, result and return to IDLE.
  task automatic run_op(input int w, input logic [7:0] a, input logic [7:0] b, input logic bi,
                        input logic [7:0] ed, input logic eb, input string tag);
    int n;
    @(posedge clk); #1;
    drive(w, 1'b1, a, b, bi);
    @(posedge clk); #1;
    drive(w, 1'b0, ~a, ~b, ~bi);
    chk({tag, "_busy"}, get_busy(w), 1'b1);
    n = 0;
    while (!get_done(w) && n < w + 4) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_latency"}, n, w);
    chk({tag, "_diff"}, get_diff(w), ed);
    chk({tag, "_bout"}, get_bout(w), eb);
    @(posedge clk); #1;
    chk({tag, "_done_width"}, get_done(w), 1'b0);
    chk({tag, "_idle"}, get_busy(w), 1'b0);
  endtask

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       bi;
    logic [3:0] ed;
    logic       eb;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] f4;
    logic [1:0] f1;
    logic [8:0] f8;
    logic [7:0] ra, rb;
    logic       rbi;
    int n;

    vecs[0] = '{4'h9, 4'h3, 1'b0, 4'h6, 1'b0};
    vecs[1] = '{4'h3, 4'h9, 1'b0, 4'hA, 1'b1};
    vecs[2] = '{4'h0, 4'h0, 1'b1, 4'hF, 1'b1};
    vecs[3] = '{4'hF, 4'hF, 1'b0, 4'h0, 1'b0};
    vecs[4] = '{4'h0, 4'h1, 1'b0, 4'hF, 1'b1};
    vecs[5] = '{4'hF, 4'h0, 1'b1, 4'hE, 1'b0};
    vecs[6] = '{4'h8, 4'h7, 1'b1, 4'h0, 1'b0};
    vecs[7] = '{4'h5, 4'h5, 1'b1, 4'hF, 1'b1};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy4, 1'b0);
    chk("rst_done", done4, 1'b0);
    chk("rst_diff", diff4, 4'h0);
    chk("rst_bout", bout4, 1'b0);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++)
      run_op(4, {4'b0, vecs[i].a}, {4'b0, vecs[i].b}, vecs[i].bi,
             {4'b0, vecs[i].ed}, vecs[i].eb, $sformatf("vec%0d", i));

    // start held high: one op every 6 cycles, done one cycle wide
    @(posedge clk); #1;
    drive(4, 1'b1, 8'h09, 8'h03, 1'b0);
    @(posedge clk); #1;
    for (int c = 0; c < 18; c++) begin
      chk($sformatf("hold_done_c%0d", c), done4, ((c % 6) == 4));
      chk($sformatf("hold_busy_c%0d", c), busy4, ((c % 6) != 5));
      if ((c % 6) == 4) chk($sformatf("hold_diff_c%0d", c), diff4, 4'h6);
      if (c == 17) start4 = 1'b0;
      @(posedge clk); #1;
    end
    chk("hold_released", busy4, 1'b0);

    // start re-pulsed mid-SHIFT is ignored
    @(posedge clk); #1;
    drive(4, 1'b1, 8'h09, 8'h03, 1'b0);
    @(posedge clk); #1;
    start4 = 1'b0;
    @(posedge clk); #1;
    drive(4, 1'b1, 8'h03, 8'h09, 1'b1);
    @(posedge clk); #1;
    start4 = 1'b0;
    n = 2;
    while (!done4 && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    chk("repulse_latency", n, 4);
    chk("repulse_diff", diff4, 4'h6);
    chk("repulse_bout", bout4, 1'b0);
    @(posedge clk); #1;
    chk("repulse_idle", busy4, 1'b0);
    @(posedge clk); #1;
    chk("repulse_no_queue", busy4, 1'b0);

    // reset during the second SHIFT cycle
    @(posedge clk); #1;
    drive(4, 1'b1, 8'h03, 8'h09, 1'b0);
    @(posedge clk); #1;
    start4 = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy4, 1'b0);
    chk("midrst_done", done4, 1'b0);
    chk("midrst_diff", diff4, 4'h0);
    chk("midrst_bout", bout4, 1'b0);
    n = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (c == 1) rst_n = 1'b1;
      if (done4) n++;
    end
    chk("midrst_no_done", n, 0);
    chk("midrst_diff_held", diff4, 4'h0);
    run_op(4, 8'h09, 8'h03, 1'b0, 8'h06, 1'b0, "after_rst");

    for (int i = 0; i < 512; i++) begin
      ra = 8'(i & 15);
      rb = 8'((i >> 4) & 15);
      rbi = 1'((i >> 8) & 1);
      f4 = {1'b0, ra[3:0]} - {1'b0, rb[3:0]} - {4'b0, rbi};
      run_op(4, ra, rb, rbi, {4'b0, f4[3:0]}, f4[4], $sformatf("w4_%0d", i));
    end

    for (int i = 0; i < 8; i++) begin
      ra = 8'(i & 1);
      rb = 8'((i >> 1) & 1);
      rbi = 1'((i >> 2) & 1);
      f1 = {1'b0, ra[0]} - {1'b0, rb[0]} - {1'b0, rbi};
      run_op(1, ra, rb, rbi, {7'b0, f1[0]}, f1[1], $sformatf("w1_%0d", i));
    end

    for (int i = 0; i < 40; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rbi = 1'($urandom_range(0, 1));
      if (i == 0) begin ra = 8'h00; rb = 8'hFF; rbi = 1'b1; end
      if (i == 1) begin ra = 8'hFF; rb = 8'h00; rbi = 1'b0; end
      f8 = {1'b0, ra} - {1'b0, rb} - {8'b0, rbi};
      run_op(8, ra, rb, rbi, f8[7:0], f8[8], $sformatf("w8_%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
